// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - CPU-to-RAM access controller for a synchronous-read RAM (optional MEM_ACCESS_FAULT_EN)
module mem_access_ctrl #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int CPU_ADDR_W = 32
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [CPU_ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_done,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_fault,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W-1:0]     ram_data_in,
    input  logic [DATA_W-1:0]     ram_data_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   mar_q;
    logic [DATA_W-1:0]   wdr_q;
    logic [DATA_W-1:0]   mdr_q;
    logic                we_q;

`ifdef MEM_ACCESS_FAULT_EN
    // Any set bit above the RAM address range makes the request out of range.
    logic                addr_hi_nz;
    logic                fault_q;
    assign addr_hi_nz = |cpu_addr[CPU_ADDR_W-1:ADDR_W];
`else
    // Upper address bits are intentionally dropped so addresses wrap in the RAM.
    logic                unused_addr_hi;
    assign unused_addr_hi = ^cpu_addr[CPU_ADDR_W-1:ADDR_W];
`endif

    // State register; async clear drops the RAM strobes immediately mid-access.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: writes skip CAPTURE, faulted requests skip the RAM entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
`ifdef MEM_ACCESS_FAULT_EN
                    state_d = addr_hi_nz ? DONE : ACCESS;
`else
                    state_d = ACCESS;
`endif
                end
            end
            ACCESS:  state_d = we_q ? DONE : CAPTURE;
            CAPTURE: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture in IDLE and read-data capture in CAPTURE; MDR is never touched by writes.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            mar_q   <= '0;
            wdr_q   <= '0;
            mdr_q   <= '0;
            we_q    <= 1'b0;
`ifdef MEM_ACCESS_FAULT_EN
            fault_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        mar_q   <= cpu_addr[ADDR_W-1:0];
                        wdr_q   <= cpu_wdata;
                        we_q    <= cpu_we;
`ifdef MEM_ACCESS_FAULT_EN
                        fault_q <= addr_hi_nz;
                        if (addr_hi_nz && !cpu_we) begin
                            mdr_q <= '0;
                        end
`endif
                    end
                end
                CAPTURE: mdr_q <= ram_data_out;
                default: ;
            endcase
        end
    end

    assign cpu_ready   = (state_q == IDLE);
    assign cpu_done    = (state_q == DONE);
    assign cpu_rdata   = mdr_q;
`ifdef MEM_ACCESS_FAULT_EN
    assign cpu_fault   = (state_q == DONE) && fault_q;
`else
    assign cpu_fault   = 1'b0;
`endif
    // RAM registers the address at the end of ACCESS; CAPTURE keeps the strobe and address steady.
    assign ram_read    = ((state_q == ACCESS) && !we_q) || (state_q == CAPTURE);
    assign ram_write   = (state_q == ACCESS) && we_q;
    assign ram_address = mar_q;
    assign ram_data_in = wdr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard testbench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ready;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_fault;
    logic        ram_read;
    logic        ram_write;
    logic [8:0]  ram_address;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_out;

    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .CPU_ADDR_W(32)) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ready    (cpu_ready),
        .cpu_done     (cpu_done),
        .cpu_rdata    (cpu_rdata),
        .cpu_fault    (cpu_fault),
        .ram_read     (ram_read),
        .ram_write    (ram_write),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    always #5 clock = ~clock;

    // RAM model: registered read address, data visible the cycle after it is latched.
    logic [31:0] mem [512];
    logic [8:0]  raddr_q = '0;
    always @(posedge clock) begin
        if (ram_write) mem[ram_address] <= ram_data_in;
        if (ram_read)  raddr_q <= ram_address;
    end
    assign ram_data_out = mem[raddr_q];

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int unsigned wr_cycles = 0;
    always @(negedge clock) if (ram_write) wr_cycles = wr_cycles + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int unsigned cyc;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected completion.
    always @(negedge clock) begin
        if (clear_n && cpu_done) begin
            if (sb.size() == 0) begin
                n_checks = n_checks + 1;
                n_fail = n_fail + 1;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_rdata", cpu_rdata, e.rdata);
                check("done_fault", {31'b0, cpu_fault}, {31'b0, e.fault});
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Present a request in an IDLE cycle; the edge closing that cycle samples it.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_fault,
                         input int lat, input bit hold, input bit push);
        int n;
        n = 0;
        @(negedge clock);
        while (!cpu_ready && n < 20) begin
            @(negedge clock);
            n = n + 1;
        end
        if (!cpu_ready) begin
            n_checks = n_checks + 1;
            n_fail = n_fail + 1;
            $display("FAIL ready_timeout: got ready=0 expected 1");
        end
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = wdata;
        if (push) sb.push_back('{rdata: exp_rdata, fault: exp_fault, cyc: cyc + lat});
        @(posedge clock);
        #1;
        if (!hold) cpu_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clock);
            n = n + 1;
        end
        if (sb.size() != 0) begin
            n_checks = n_checks + 1;
            n_fail = n_fail + 1;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        mem[149] = 32'h0000_0022;
        mem[90]  = 32'h0000_0012;

        // Reset values
        #12;
        check("rst_ready", {31'b0, cpu_ready}, 32'd1);
        check("rst_done", {31'b0, cpu_done}, 32'd0);
        check("rst_fault", {31'b0, cpu_fault}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_ram_read", {31'b0, ram_read}, 32'd0);
        check("rst_ram_write", {31'b0, ram_write}, 32'd0);
        check("rst_ram_address", {23'b0, ram_address}, 32'd0);
        check("rst_ram_data_in", ram_data_in, 32'd0);
        @(negedge clock);
        clear_n = 1'b1;

        // Read 0x95: address driven in ACCESS, done three cycles after presentation
        issue(1'b0, 32'h95, 32'h0, 32'h22, 1'b0, 3, 1'b0, 1'b1);
        check("access_addr", {23'b0, ram_address}, 32'h95);
        check("access_read", {31'b0, ram_read}, 32'd1);
        check("access_ready", {31'b0, cpu_ready}, 32'd0);
        drain();

        // Write 0x87: one-cycle write strobe, MDR keeps the previous read
        wr_cycles = 0;
        issue(1'b1, 32'h87, 32'hDEAD_BEEF, 32'h22, 1'b0, 2, 1'b0, 1'b1);
        check("write_data_in", ram_data_in, 32'hDEAD_BEEF);
        drain();
        check("write_pulse_len", wr_cycles, 32'd1);
        check("write_mem", mem[135], 32'hDEAD_BEEF);

        issue(1'b0, 32'h87, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1'b0, 1'b1);
        drain();

        // Request held high: second request taken only on return to IDLE
        issue(1'b0, 32'h95, 32'h0, 32'h22, 1'b0, 3, 1'b1, 1'b1);
        issue(1'b0, 32'h5A, 32'h0, 32'h12, 1'b0, 3, 1'b0, 1'b1);
        drain();

        // Inputs changed mid-access are ignored
        issue(1'b0, 32'h95, 32'h0, 32'h22, 1'b0, 3, 1'b0, 1'b1);
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 32'h1FF;
        cpu_wdata = 32'h0000_0BAD;
        @(posedge clock);
        #1;
        check("capture_addr", {23'b0, ram_address}, 32'h95);
        check("capture_no_write", {31'b0, ram_write}, 32'd0);
        cpu_req = 1'b0;
        @(posedge clock);
        #1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        drain();
        check("ignored_mem_1ff", mem[511], 32'd0);

        // Reset during ACCESS of a write aborts it without a done pulse
        issue(1'b1, 32'h10, 32'h55, 32'h0, 1'b0, 2, 1'b0, 1'b0);
        check("abort_write_before", {31'b0, ram_write}, 32'd1);
        clear_n = 1'b0;
        #1;
        check("abort_write_drop", {31'b0, ram_write}, 32'd0);
        check("abort_ready", {31'b0, cpu_ready}, 32'd1);
        check("abort_rdata", cpu_rdata, 32'd0);
        @(posedge clock);
        @(negedge clock);
        clear_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("abort_mem_10", mem[16], 32'd0);

`ifdef MEM_ACCESS_FAULT_EN
        // Out-of-range write faults without touching RAM
        issue(1'b1, 32'h200, 32'h99, 32'h0, 1'b1, 1, 1'b0, 1'b1);
        drain();
        check("oor_write_mem0", mem[0], 32'd0);
        issue(1'b0, 32'h300, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b1);
        drain();
`else
        // Out-of-range write wraps onto word 0
        issue(1'b1, 32'h200, 32'h99, 32'h0, 1'b0, 2, 1'b0, 1'b1);
        drain();
        check("wrap_write_mem0", mem[0], 32'h99);
        issue(1'b0, 32'h300, 32'h0, 32'h0, 1'b0, 3, 1'b0, 1'b1);
        drain();
`endif

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
